// File: rtl/ibex_offload_result_wb.sv
// Offloaded-instruction writeback: tracks issued IDs, buffers coprocessor
// results and drains them into the RF write port when the core is idle.
module ibex_offload_result_wb #(
  parameter int unsigned ResultDepth    = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdWidth        = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  offload_issue_i,
  input  logic [IdWidth-1:0]                    offload_issue_id_i,
  output logic                                  issue_ready_o,
  input  logic                                  result_valid_i,
  output logic                                  result_ready_o,
  input  logic [IdWidth-1:0]                    result_id_i,
  input  logic [4:0]                            result_rd_i,
  input  logic [31:0]                           result_data_i,
  input  logic                                  result_we_i,
  input  logic                                  result_err_i,
  input  logic                                  core_rf_we_i,
  output logic                                  rf_we_o,
  output logic [4:0]                            rf_waddr_o,
  output logic [31:0]                           rf_wdata_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_cnt_o,
  output logic                                  instr_done_offload_o,
  output logic                                  instr_done_err_o,
  output logic                                  id_mismatch_o
);

  localparam int unsigned RPW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
  localparam int unsigned TPW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned RCW = $clog2(ResultDepth + 1);
  localparam int unsigned TCW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic [31:0]        data;
    logic               we;
    logic               err;
  } res_t;

  res_t               res_q [ResultDepth];
  logic [RPW-1:0]     res_rd_q, res_wr_q;
  logic [RCW-1:0]     res_cnt_q;

  logic [IdWidth-1:0] trk_q [MaxOutstanding];
  logic [TPW-1:0]     trk_rd_q, trk_wr_q;
  logic [TCW-1:0]     trk_cnt_q;

  logic               mismatch_q;

  res_t               head;
  logic               res_empty, res_full;
  logic               trk_empty;
  logic               res_push, pop;
  logic               trk_push, trk_pop;
  logic               mismatch_set;
  logic [RPW-1:0]     res_rd_nxt, res_wr_nxt;
  logic [TPW-1:0]     trk_rd_nxt, trk_wr_nxt;

  assign res_empty = (res_cnt_q == '0);
  assign res_full  = (res_cnt_q == RCW'(ResultDepth));
  assign trk_empty = (trk_cnt_q == '0);
  assign head      = res_q[res_rd_q];

  assign issue_ready_o  = (trk_cnt_q != TCW'(MaxOutstanding));
  assign result_ready_o = ~res_full;

  assign res_push = result_valid_i & result_ready_o;
  assign trk_push = offload_issue_i & issue_ready_o;

  // Non-writing and faulting results never contend for the RF port.
  assign pop     = ~res_empty & (~head.we | head.err | ~core_rf_we_i);
  assign trk_pop = pop & ~trk_empty;

  assign mismatch_set = pop & (trk_empty | (trk_q[trk_rd_q] != head.id));

  assign rf_we_o    = pop & head.we & ~head.err & (head.rd != 5'd0);
  assign rf_waddr_o = res_empty ? 5'd0 : head.rd;
  assign rf_wdata_o = res_empty ? 32'd0 : head.data;

  assign instr_done_offload_o = pop;
  assign instr_done_err_o     = pop & head.err;
  assign outstanding_cnt_o    = trk_cnt_q;
  assign id_mismatch_o        = mismatch_q;

  assign res_rd_nxt = (res_rd_q == RPW'(ResultDepth - 1)) ? '0 : res_rd_q + 1'b1;
  assign res_wr_nxt = (res_wr_q == RPW'(ResultDepth - 1)) ? '0 : res_wr_q + 1'b1;
  assign trk_rd_nxt = (trk_rd_q == TPW'(MaxOutstanding - 1)) ? '0 : trk_rd_q + 1'b1;
  assign trk_wr_nxt = (trk_wr_q == TPW'(MaxOutstanding - 1)) ? '0 : trk_wr_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ResultDepth); i++) res_q[i] <= '0;
      res_rd_q  <= '0;
      res_wr_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (res_push) begin
        res_q[res_wr_q] <= '{id:   result_id_i,
                             rd:   result_rd_i,
                             data: result_data_i,
                             we:   result_we_i,
                             err:  result_err_i};
        res_wr_q <= res_wr_nxt;
      end
      if (pop) res_rd_q <= res_rd_nxt;
      unique case ({res_push, pop})
        2'b10:   res_cnt_q <= res_cnt_q + 1'b1;
        2'b01:   res_cnt_q <= res_cnt_q - 1'b1;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) trk_q[i] <= '0;
      trk_rd_q  <= '0;
      trk_wr_q  <= '0;
      trk_cnt_q <= '0;
    end else begin
      if (trk_push) begin
        trk_q[trk_wr_q] <= offload_issue_id_i;
        trk_wr_q        <= trk_wr_nxt;
      end
      if (trk_pop) trk_rd_q <= trk_rd_nxt;
      unique case ({trk_push, trk_pop})
        2'b10:   trk_cnt_q <= trk_cnt_q + 1'b1;
        2'b01:   trk_cnt_q <= trk_cnt_q - 1'b1;
        default: trk_cnt_q <= trk_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mismatch_q <= 1'b0;
    else if (mismatch_set) mismatch_q <= 1'b1;
  end

endmodule
